// File: rtl/apb_reg_bank_backend.sv
// -----------------------------------------------------------------------------
// apb_reg_bank_backend
//
// Register-bank target sitting behind the APB slave bridge. Accepts one
// request at a time from the bridge request channel, stays busy for
// WAIT_CYCLES extra cycles, then commits a write or returns read data. Any
// misaligned or out-of-range access completes with a one-cycle o_err strobe.
//
// Optional feature (compile-time macro REG_BANK_ID_REG_EN):
//   defined   -> index 0 is a read-only ID register returning ID_VALUE;
//                writes to it are silently dropped with no error.
//   undefined -> index 0 is an ordinary read/write register.
//
// Ports:
//   i_clk_apb   clock, rising edge
//   i_rstn_apb  asynchronous active-low reset
//   i_valid     request valid from the bridge
//   i_rd0_wr1   0 = read, 1 = write
//   i_addr      byte address
//   i_wr_data   write data
//   o_rd_data   read data, held until the next read completion
//   o_rd_valid  one-cycle read-complete strobe
//   o_ready     high while idle and able to accept a request
//   o_err       one-cycle error strobe, coincident with completion
// -----------------------------------------------------------------------------
module apb_reg_bank_backend #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA11B_0001)
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rstn_apb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_ready,
  output logic                  o_err
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      WAIT_LD  = CNT_W'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    legal_q, legal_d;
  logic                    wr_q, wr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic req_legal;
  logic id_hit;

  // NUM_REGS is a power of two, so "index < NUM_REGS" reduces to all address
  // bits above the index field being zero.
  assign req_legal = (i_addr[1:0] == 2'b00) &&
                     (i_addr[ADDR_WIDTH-1:IDX_W+2] == '0);

`ifdef REG_BANK_ID_REG_EN
  assign id_hit = (idx_q == '0);
`else
  assign id_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    legal_d    = legal_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    regs_d     = regs_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          wr_d    = i_rd0_wr1;
          idx_d   = i_addr[IDX_W+1:2];
          wdata_d = i_wr_data;
          legal_d = req_legal;
          cnt_d   = WAIT_LD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          err_d   = !legal_q;
          if (wr_q) begin
            if (legal_q && !id_hit) begin
              regs_d[idx_q] = wdata_q;
            end
          end else begin
            rd_valid_d = 1'b1;
            if (!legal_q) begin
              rd_data_d = BAD_DATA;
            end else if (id_hit) begin
              rd_data_d = ID_VALUE;
            end else begin
              rd_data_d = regs_q[idx_q];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      legal_q    <= 1'b0;
      wr_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      legal_q    <= legal_d;
      wr_q       <= wr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
    end
  end

  // Captured index and write data are only consumed in BUSY, which is always
  // entered through a capture, so they need no reset.
  always_ff @(posedge i_clk_apb) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  assign o_ready    = (state_q == IDLE);
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_apb_reg_bank_backend.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_bank_backend
//
// Directed bench for apb_reg_bank_backend with default parameters
// (WAIT_CYCLES = 2, NUM_REGS = 16). Stimulus pushes expected strobe responses
// into a queue; a monitor pops and compares whenever o_rd_valid or o_err is
// seen. Honors REG_BANK_ID_REG_EN for the index-0 expectations.
// -----------------------------------------------------------------------------
module tb_apb_reg_bank_backend;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam int WC = 2;

`ifdef REG_BANK_ID_REG_EN
  localparam logic [31:0] R0_A = 32'hA11B_0001;
  localparam logic [31:0] R0_B = 32'hA11B_0001;
`else
  localparam logic [31:0] R0_A = 32'h3333_3333;
  localparam logic [31:0] R0_B = 32'h5555_5555;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          i_rd0_wr1;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wr_data;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_ready;
  logic          o_err;

  apb_reg_bank_backend #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .WAIT_CYCLES(WC)
  ) dut (
    .i_clk_apb (clk),
    .i_rstn_apb(rst_n),
    .i_valid   (i_valid),
    .i_rd0_wr1 (i_rd0_wr1),
    .i_addr    (i_addr),
    .i_wr_data (i_wr_data),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_ready   (o_ready),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && (o_rd_valid || o_err)) begin
      if (sb.size() == 0) begin
        chk("stray_strobe", {62'd0, o_rd_valid, o_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_valid", {63'd0, o_rd_valid}, {63'd0, e.is_rd});
        chk("err", {63'd0, o_err}, {63'd0, e.err});
        if (e.is_rd) chk("rd_data", {32'd0, o_rd_data}, {32'd0, e.data});
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one request at a negedge; returns at the negedge where o_ready is
  // back high. i_valid is left asserted so consecutive calls hold it high.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [31:0] exp_rd);
    int   n;
    exp_t e;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", {63'd0, o_ready}, 64'd1);
    i_valid   = 1'b1;
    i_rd0_wr1 = wr;
    i_addr    = addr;
    i_wr_data = data;
    if (!wr || exp_err) begin
      e.is_rd = !wr;
      e.err   = exp_err;
      e.data  = exp_rd;
      e.cyc   = cyc + WC + 2;
      sb.push_back(e);
    end
    for (int k = 0; k <= WC; k++) begin
      @(negedge clk);
      chk("ready_low_busy", {63'd0, o_ready}, 64'd0);
    end
    @(negedge clk);
    chk("ready_after_done", {63'd0, o_ready}, 64'd1);
  endtask

  task automatic idle();
    i_valid   = 1'b0;
    i_rd0_wr1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    i_valid   = 1'b0;
    i_rd0_wr1 = 1'b0;
    i_addr    = '0;
    i_wr_data = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_rd_valid", {63'd0, o_rd_valid}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    chk("rst_rd_data", {32'd0, o_rd_data}, 64'd0);
    access(1'b0, 32'h14, 32'h0, 1'b0, 32'h0);
    idle();

    // Write then read
    access(1'b1, 32'h08, 32'h1234_5678, 1'b0, 32'h0);
    idle();
    access(1'b0, 32'h08, 32'h0, 1'b0, 32'h1234_5678);
    idle();

    // Illegal accesses
    access(1'b1, 32'h0A, 32'hFFFF_FFFF, 1'b1, 32'h0);
    idle();
    chk("rd_data_hold_on_write", {32'd0, o_rd_data}, {32'd0, 32'h1234_5678});
    access(1'b0, 32'h08, 32'h0, 1'b0, 32'h1234_5678);
    idle();
    access(1'b0, 32'h0C, 32'h0, 1'b0, 32'h0);
    idle();
    access(1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF);
    idle();

    // Last legal index
    access(1'b1, 32'h3C, 32'h0BAD_F00D, 1'b0, 32'h0);
    idle();
    access(1'b0, 32'h3C, 32'h0, 1'b0, 32'h0BAD_F00D);
    idle();

    // i_valid held high continuously, back-to-back accepts
    access(1'b1, 32'h00, 32'h1111_1111, 1'b0, 32'h0);
    access(1'b1, 32'h04, 32'h2222_2222, 1'b0, 32'h0);
    access(1'b1, 32'h00, 32'h3333_3333, 1'b0, 32'h0);
    access(1'b1, 32'h04, 32'h4444_4444, 1'b0, 32'h0);
    access(1'b0, 32'h04, 32'h0, 1'b0, 32'h4444_4444);
    access(1'b0, 32'h00, 32'h0, 1'b0, R0_A);
    idle();

    // Reset in the middle of a write
    i_valid   = 1'b1;
    i_rd0_wr1 = 1'b1;
    i_addr    = 32'h0C;
    i_wr_data = 32'hCAFE_0000;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    chk("midrst_rd_data", {32'd0, o_rd_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h0C, 32'h0, 1'b0, 32'h0);
    idle();
    access(1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    idle();

    // Index 0 behaviour (ID register when enabled)
    access(1'b1, 32'h00, 32'h5555_5555, 1'b0, 32'h0);
    idle();
    access(1'b0, 32'h00, 32'h0, 1'b0, R0_B);
    idle();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
